bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning word length in bits; legal range 2..32.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 1, meaning idle-low cycles inserted after each word; legal range 0..15.
REQ-003 The block SHALL have parameter LSB_FIRST, default 0, meaning 0 = MSB transmitted first and 1 = LSB first.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 data_in  input  WIDTH  parallel word to transmit.
REQ-007 valid_in  input  1  data_in is valid.
REQ-008 ready_out  output  1  block can accept a word this cycle.
REQ-009 x  output  1  serial bit stream to the downstream serial consumer.
REQ-010 busy  output  1  high while a word or its gap is in progress.
REQ-011 done  output  1  one-cycle pulse marking the end of a word's last bit.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and GAP; unused encodings SHALL return to IDLE on the next edge.
REQ-013 ready_out SHALL be 1 exactly when state = IDLE and rst = 0; it SHALL be a pure function of state.
REQ-014 A word SHALL be accepted on a posedge where valid_in = 1 and ready_out = 1; data_in SHALL be loaded into the shift register, the bit counter SHALL be set to WIDTH-1, and the state SHALL become SHIFT.
REQ-015 valid_in while ready_out = 0 SHALL be ignored; no data is captured or queued.
REQ-016 In SHIFT, x SHALL equal shreg[WIDTH-1] (LSB_FIRST = 0) or shreg[0] (LSB_FIRST = 1); in IDLE and GAP, x SHALL be 0.
REQ-017 Each SHIFT cycle SHALL shift the register one position toward the output end, zero-filled, and decrement the counter.
REQ-018 In SHIFT with counter = 0: next state SHALL be GAP with the gap counter set to GAP_CYCLES-1 if GAP_CYCLES > 0, else IDLE.
REQ-019 In GAP with gap counter = 0, next state SHALL be IDLE; otherwise the gap counter SHALL decrement.
REQ-020 Latency: the first bit SHALL appear on x in the cycle immediately after the accepting edge; bit WIDTH-1 (last) SHALL appear WIDTH cycles after acceptance.
REQ-021 Throughput: word period SHALL be exactly WIDTH + GAP_CYCLES + 1 cycles with valid_in held high.
REQ-022 done SHALL be registered and high for exactly the one cycle following the last SHIFT cycle, including when GAP_CYCLES = 0.
REQ-023 busy SHALL be 1 in SHIFT and GAP, and 0 in IDLE.
REQ-024 Changes on data_in or valid_in during SHIFT or GAP SHALL NOT affect the word in flight.

Reset
REQ-025 While rst = 1 at posedge, state SHALL become IDLE, and the shift register, bit counter, gap counter and done SHALL become 0.
REQ-026 Outputs during and after reset SHALL be x = 0, busy = 0 and done = 0; ready_out SHALL be 0 while rst = 1 and 1 on the first cycle after rst falls.
REQ-027 Reset asserted mid-word SHALL abort the word at once; no done pulse SHALL occur and there SHALL be no resumption.
REQ-028 rst SHALL take priority over a simultaneous valid_in handshake; that word SHALL be dropped.

Structure
REQ-029 State encodings (IDLE = 0, SHIFT = 1, GAP = 2) and the idle line level (0) SHALL be defined in a shared package, serializer_pkg, reused by the bench.
REQ-030 The implementation SHALL use one sub-module, down_counter, with load, enable, zero flag and a parameterised width, instanced for the bit counter and the gap counter.
REQ-031 The implementation SHALL use a two-process FSM style: one sequential block for state and datapath, and one combinational block for next state and outputs with defaults assigned first.

Verification
REQ-032 WIDTH = 8, GAP_CYCLES = 1, LSB_FIRST = 0; send 8'hA5 -> x = 1,0,1,0,0,1,0,1 on cycles 1..8 after accept; cycle 9: done = 1, x = 0; ready_out = 1 at cycle 10.
REQ-033 Same configuration, LSB_FIRST = 1, send 8'h01 -> x = 1 on cycle 1, then 0 for cycles 2..8.
REQ-034 GAP_CYCLES = 0, valid_in held high with 8'hFF then 8'h00 -> second accept 9 cycles after the first; x shows eight 1s, one 0, eight 0s; two done pulses.
REQ-035 Assert rst for 1 cycle at bit 4 of 8'hF0 -> x = 0 and busy = 0 the next cycle, no done pulse, ready_out = 1 the cycle after rst falls.
REQ-036 Toggle data_in and valid_in randomly during SHIFT -> x sequence equals the originally accepted word; no extra accept occurs.
REQ-037 Pair with the downstream serial consumer; send 8'b1101_0000 with GAP_CYCLES = 2 -> the consumer output matches a golden bit-level model cycle for cycle.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared definitions for the bit serializer: FSM encodings and idle line level.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic IDLE_LEVEL = 1'b0;

  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter that saturates at zero and flags when it holds zero.
module down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: one word per handshake, optional idle gap, done pulse after the last bit.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1,
  parameter bit LSB_FIRST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             x,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] BIT_LOAD = CW'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             done_q, done_d;
  logic             bit_load, bit_en, bit_zero;
  logic             gap_load, gap_en, gap_zero;

  down_counter #(.W(CW)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (bit_load),
    .en       (bit_en),
    .load_val (BIT_LOAD),
    .zero     (bit_zero)
  );

  down_counter #(.W(GAP_CNT_W)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .en       (gap_en),
    .load_val (GAP_LOAD),
    .zero     (gap_zero)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;
    bit_load  = 1'b0;
    bit_en    = 1'b0;
    gap_load  = 1'b0;
    gap_en    = 1'b0;
    x         = IDLE_LEVEL;
    busy      = 1'b0;
    ready_out = 1'b0;
    case (state_q)
      IDLE: begin
        ready_out = !rst;
        if (valid_in) begin
          shreg_d  = data_in;
          bit_load = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        busy   = 1'b1;
        bit_en = 1'b1;
        if (LSB_FIRST) begin
          x       = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end else begin
          x       = shreg_q[WIDTH-1];
          shreg_d = shreg_q << 1;
        end
        if (bit_zero) begin
          done_d = 1'b1;
          if (GAP_CYCLES > 0) begin
            gap_load = 1'b1;
            state_d  = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        busy = 1'b1;
        if (gap_zero) begin
          state_d = IDLE;
        end else begin
          gap_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset wins over any handshake on the same edge, dropping that word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer across four parameter sets, with a per-cycle expectation queue.
module tb_bit_serializer;
  import serializer_pkg::*;

  typedef struct packed {
    logic x;
    logic busy;
    logic done;
    logic ready;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_w  [4];
  logic       valid_w [4];
  logic       ready_w [4];
  logic       x_w     [4];
  logic       busy_w  [4];
  logic       done_w  [4];
  int         checks   = 0;
  int         failures = 0;
  exp_t       exp_q[$];
  logic [7:0] cons_q = '0;

  always #5 clk = ~clk;

  // Downstream consumer on instance 3: collects the serial stream MSB-first.
  always @(posedge clk) cons_q <= {cons_q[6:0], x_w[3]};

  bit_serializer #(.WIDTH(8), .GAP_CYCLES(1), .LSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst(rst), .data_in(data_w[0]), .valid_in(valid_w[0]),
    .ready_out(ready_w[0]), .x(x_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  bit_serializer #(.WIDTH(8), .GAP_CYCLES(1), .LSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst(rst), .data_in(data_w[1]), .valid_in(valid_w[1]),
    .ready_out(ready_w[1]), .x(x_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  bit_serializer #(.WIDTH(8), .GAP_CYCLES(0), .LSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst(rst), .data_in(data_w[2]), .valid_in(valid_w[2]),
    .ready_out(ready_w[2]), .x(x_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  bit_serializer #(.WIDTH(8), .GAP_CYCLES(2), .LSB_FIRST(1'b0)) u_d (
    .clk(clk), .rst(rst), .data_in(data_w[3]), .valid_in(valid_w[3]),
    .ready_out(ready_w[3]), .x(x_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Golden per-cycle view of one word, cycles 1..WIDTH+gap+1 after the accepting edge.
  task automatic push_word(input logic [7:0] w, input bit lsb, input int gap);
    exp_t e;
    for (int k = 1; k <= 9 + gap; k++) begin
      e.x     = (k <= 8) ? (lsb ? w[k-1] : w[8-k]) : IDLE_LEVEL;
      e.busy  = (k <= 8 + gap);
      e.done  = (k == 9);
      e.ready = (k == 9 + gap);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    e = '{x: IDLE_LEVEL, busy: 1'b0, done: 1'b0, ready: 1'b1};
    for (int k = 0; k < n; k++) exp_q.push_back(e);
  endtask

  task automatic run_check(input int idx, input string tag, input bit rnd, input logic [7:0] cword);
    exp_t e;
    int   k;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      k++;
      chk($sformatf("%s.x[%0d]", tag, k), 32'(x_w[idx]), 32'(e.x));
      chk($sformatf("%s.busy[%0d]", tag, k), 32'(busy_w[idx]), 32'(e.busy));
      chk($sformatf("%s.done[%0d]", tag, k), 32'(done_w[idx]), 32'(e.done));
      chk($sformatf("%s.ready[%0d]", tag, k), 32'(ready_w[idx]), 32'(e.ready));
      if (idx == 3 && e.done) chk({tag, ".consumer"}, 32'(cons_q), 32'(cword));
      if (rnd) begin
        if (k <= 8) begin
          data_w[0]  = 8'($urandom);
          valid_w[0] = 1'($urandom_range(0, 1));
        end else begin
          valid_w[0] = 1'b0;
        end
      end
    end
  endtask

  task automatic send(input int idx, input logic [7:0] w);
    data_w[idx]  = w;
    valid_w[idx] = 1'b1;
    @(posedge clk);
    #1 valid_w[idx] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_w[i]  = '0;
      valid_w[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst.ready%0d", i), 32'(ready_w[i]), 32'd0);
      chk($sformatf("rst.x%0d", i), 32'(x_w[i]), 32'd0);
      chk($sformatf("rst.busy%0d", i), 32'(busy_w[i]), 32'd0);
      chk($sformatf("rst.done%0d", i), 32'(done_w[i]), 32'd0);
    end
    rst = 1'b0;
    push_idle(1);
    run_check(0, "post_rst", 1'b0, 8'h00);

    send(0, 8'hA5);
    push_word(8'hA5, 1'b0, 1);
    run_check(0, "msb_a5", 1'b0, 8'h00);

    send(1, 8'h01);
    push_word(8'h01, 1'b1, 1);
    run_check(1, "lsb_01", 1'b0, 8'h00);

    // Back-to-back words with valid held and no gap.
    data_w[2]  = 8'hFF;
    valid_w[2] = 1'b1;
    @(posedge clk);
    #1 data_w[2] = 8'h00;
    push_word(8'hFF, 1'b0, 0);
    push_word(8'h00, 1'b0, 0);
    run_check(2, "b2b", 1'b0, 8'h00);
    valid_w[2] = 1'b0;
    push_idle(2);
    run_check(2, "b2b_end", 1'b0, 8'h00);

    // Reset after four bits of F0: word aborted, no done, no resumption.
    send(0, 8'hF0);
    push_word(8'hF0, 1'b0, 1);
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    run_check(0, "abort", 1'b0, 8'h00);
    rst = 1'b1;
    #1 chk("abort.ready_in_rst", 32'(ready_w[0]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    push_idle(10);
    run_check(0, "abort_after", 1'b0, 8'h00);

    // Reset coinciding with a handshake drops the word.
    data_w[0]  = 8'hAA;
    valid_w[0] = 1'b1;
    rst        = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    valid_w[0] = 1'b0;
    push_idle(3);
    run_check(0, "rst_prio", 1'b0, 8'h00);

    // Inputs toggled while a word is in flight.
    send(0, 8'h3C);
    push_word(8'h3C, 1'b0, 1);
    run_check(0, "toggle", 1'b1, 8'h00);
    push_idle(3);
    run_check(0, "toggle_end", 1'b0, 8'h00);

    send(3, 8'b1101_0000);
    push_word(8'b1101_0000, 1'b0, 2);
    run_check(3, "consumer", 1'b0, 8'b1101_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
